cnt_sequencer: RTL and testbench
================================

// Module: cnt_sequencer
// PURPOSE
// - Run controller for the 4-bit free-running counter datapath. It turns the bare counter into a
//   programmable timer: start, stop, pause, up or down direction, one-shot or periodic mode.
// - Sits between software/bench control strobes and the counter. The counter is instantiated
//   inside this block, so the sequencer owns the count value outright.
// PARAMETERS
// - WIDTH   4   counter width in bits; tc and cnt are WIDTH wide
// PORTS
// - clk            in   1      single system clock, rising edge
// - rst            in   1      asynchronous, active-high reset
// - start          in   1      level, sampled each edge; begins a run from IDLE
// - stop           in   1      level; aborts the run from any state
// - pause          in   1      level; holds the count while high (RUN<->PAUSE)
// - tc             in   WIDTH  terminal count; latched on an accepted start
// - dir_down       in   1      0 = count 0->tc, 1 = count tc->0; latched on start
// - periodic       in   1      0 = one-shot, 1 = auto-reload; latched on start
// - cnt            out  WIDTH  current count
// - busy           out  1      high in RUN and PAUSE
// - wrap           out  1      one-cycle pulse on each periodic reload
// - done           out  1      high for exactly the one cycle spent in DONE
// BEHAVIOUR
// - Reset (async, any time, including mid-run): state=IDLE, cnt=0, busy=0, wrap=0, done=0,
//   latched tc/dir/mode=0. All outputs are registered.
// - Definitions: start value S = dir_down ? tc_l : 0; end value E = dir_down ? 0 : tc_l.
// - Priority per edge: stop > start > pause > step.
// - IDLE
//   - start=1: latch tc, dir_down, periodic; cnt<=S; go RUN.
//   - Otherwise cnt holds its last value.
// - RUN
//   - stop=1: go IDLE, cnt<=0.
//   - pause=1: go PAUSE, cnt holds.
//   - cnt!=E: cnt steps +1 (up) or -1 (down).
//   - cnt==E, one-shot: go DONE, cnt holds at E.
//   - cnt==E, periodic: cnt<=S and wrap=1 for that cycle; stay RUN.
//   - start=1 is ignored; there is no restart mid-run.
// - PAUSE
//   - stop=1: go IDLE, cnt<=0.
//   - pause=0: go RUN; stepping resumes on the following edge. No count is lost or duplicated.
// - DONE: done=1. The next edge goes IDLE with cnt held.
//   - start=1 on that edge restarts directly: latch inputs, cnt<=S, go RUN.
//   - stop=1 on that edge: IDLE with cnt<=0.
// - Latency: start accepted on edge N -> cnt=S and busy=1 after edge N.
//   - One-shot run takes tc_l+1 RUN cycles, then 1 DONE cycle.
// - Boundaries
//   - tc=0: S==E. One-shot gives exactly one RUN cycle then DONE. Periodic gives wrap=1 on every
//     RUN cycle with cnt=0.
//   - tc=2^WIDTH-1: counts the full range. No arithmetic overflow occurs because the reload or
//     stop happens at E.
//   - Live tc/dir/periodic changes during a run have no effect until the next start.
//   - stop and pause together: stop wins.
//   - pause held during DONE or IDLE: no effect.
// STRUCTURE
// - Shared package cnt_seq_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1,
//   ST_PAUSE=2'd2, ST_DONE=2'd3, and the default WIDTH.
// - One sub-module, cnt_core: registered WIDTH-bit counter with load (value), enable and dir
//   inputs, async active-high rst. The FSM, input latches and pulse logic live in the top level.
// TESTING
// - Reset mid-count: run up with tc=9, assert rst while cnt=4 -> cnt=0, busy=0, state IDLE,
//   asynchronously (before the next clk edge).
// - One-shot up, tc=5: start for 1 cycle.
//   - cnt sequence 0,1,2,3,4,5 with busy=1, then done=1 for 1 cycle with cnt=5.
//   - Then IDLE, busy=0, cnt stays 5.
// - Periodic down, tc=3: sequence 3,2,1,0,3,2,...
//   - wrap=1 exactly on the cycles where cnt goes 0->3. done stays 0 throughout.
// - Pause/stop: one-shot up tc=15, pause high 3 cycles at cnt=6.
//   - cnt holds 6 for those cycles, then resumes 7,8,...
//   - Later assert stop+pause together at cnt=10 -> IDLE, cnt=0, no done pulse.
// - tc=0 one-shot: start -> one RUN cycle with cnt=0, done=1 on the next cycle.
//   - Start held high through DONE -> immediate restart, busy=1 again.
// - Ignored inputs: change tc to 2 and toggle start mid-run (original tc=7, up).
//   - The run still reaches 7 and pulses done once.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared state encoding and default width for the counter sequencer
package cnt_seq_pkg;
   localparam int CNT_WIDTH = 4;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/cnt_seq_core.sv
// cnt_core: registered up/down counter with synchronous load and step enable
module cnt_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_dir_down,
   output logic [WIDTH-1:0] o_cnt
);
   // load wins over stepping; otherwise step by one in the requested direction
   always_ff @(posedge clk or posedge rst)
      if (rst)
         o_cnt <= '0;
      else if (i_load)
         o_cnt <= i_load_val;
      else if (i_en)
         o_cnt <= i_dir_down ? o_cnt - 1'b1 : o_cnt + 1'b1;
endmodule

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: start/stop/pause run controller wrapped around a counter core
module cnt_sequencer
   import cnt_seq_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] tc,
   input  logic             dir_down,
   input  logic             periodic,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             wrap,
   output logic             done
);
   state_t           r_state;
   logic [WIDTH-1:0] r_tc;
   logic             r_dir;
   logic             r_per;
   logic             r_busy;
   logic             r_wrap;
   logic             r_done;
   logic [WIDTH-1:0] w_cnt;
   logic [WIDTH-1:0] w_s_new;
   logic [WIDTH-1:0] w_s_lat;
   logic [WIDTH-1:0] w_e_lat;
   logic [WIDTH-1:0] w_load_val;
   logic             w_at_end;
   logic             w_accept;
   logic             w_stepping;
   logic             w_reload;
   logic             w_load;
   logic             w_en;
   // start/end values, and what the counter does this edge (stop > start > pause > step)
   always_comb begin
      w_s_new    = dir_down ? tc : '0;
      w_s_lat    = r_dir ? r_tc : '0;
      w_e_lat    = r_dir ? '0 : r_tc;
      w_at_end   = (w_cnt == w_e_lat);
      w_accept   = !stop && start && (r_state == ST_IDLE || r_state == ST_DONE);
      w_stepping = (r_state == ST_RUN) && !stop && !pause;
      w_reload   = w_stepping && w_at_end && r_per;
      w_en       = w_stepping && !w_at_end;
      w_load     = stop || w_accept || w_reload;
      w_load_val = stop ? '0 : (w_accept ? w_s_new : w_s_lat);
   end
   cnt_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_en),
      .i_dir_down (r_dir),
      .o_cnt      (w_cnt)
   );
   // run-state machine with input latches and registered status pulses
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= ST_IDLE;
         r_tc    <= '0;
         r_dir   <= 1'b0;
         r_per   <= 1'b0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_wrap <= w_reload;
         r_done <= 1'b0;
         if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else if (w_accept) begin
            r_state <= ST_RUN;
            r_tc    <= tc;
            r_dir   <= dir_down;
            r_per   <= periodic;
            r_busy  <= 1'b1;
         end else
            case (r_state)
               ST_RUN:
                  if (pause)
                     r_state <= ST_PAUSE;
                  else if (w_at_end && !r_per) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               ST_PAUSE: if (!pause) r_state <= ST_RUN;
               ST_DONE:  r_state <= ST_IDLE;
               default:  r_state <= ST_IDLE;
            endcase
      end
   assign cnt  = w_cnt;
   assign busy = r_busy;
   assign wrap = r_wrap;
   assign done = r_done;
endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: directed checks of the counter sequencer against hand-computed values
module tb_cnt_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] tc = '0;
   logic       dir_down = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] cnt;
   logic       busy;
   logic       wrap;
   logic       done;
   int         total = 0;
   int         bad = 0;
   cnt_sequencer #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .tc       (tc),
      .dir_down (dir_down),
      .periodic (periodic),
      .cnt      (cnt),
      .busy     (busy),
      .wrap     (wrap),
      .done     (done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int e;
      int w;
      step();
      step();
      chk("reset_cnt", 32'(cnt), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_wrap", 32'(wrap), 0);
      chk("reset_done", 32'(done), 0);
      rst = 1'b0;
      // reset mid-count
      tc = 4'd9; start = 1'b1;
      step();
      start = 1'b0;
      chk("rm_start_cnt", 32'(cnt), 0);
      chk("rm_start_busy", 32'(busy), 1);
      for (int i = 0; i < 4; i++) step();
      chk("rm_cnt4", 32'(cnt), 4);
      rst = 1'b1;
      #2;
      chk("rm_async_cnt", 32'(cnt), 0);
      chk("rm_async_busy", 32'(busy), 0);
      step();
      rst = 1'b0;
      step();
      chk("rm_idle_cnt", 32'(cnt), 0);
      chk("rm_idle_busy", 32'(busy), 0);
      // one-shot up, tc=5
      tc = 4'd5; dir_down = 1'b0; periodic = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         chk("os_cnt", 32'(cnt), 32'(i));
         chk("os_busy", 32'(busy), 1);
         chk("os_done", 32'(done), 0);
         step();
      end
      chk("os_done_pulse", 32'(done), 1);
      chk("os_done_cnt", 32'(cnt), 5);
      chk("os_done_busy", 32'(busy), 0);
      step();
      chk("os_idle_done", 32'(done), 0);
      chk("os_idle_busy", 32'(busy), 0);
      chk("os_idle_cnt", 32'(cnt), 5);
      step();
      chk("os_idle_hold", 32'(cnt), 5);
      // periodic down, tc=3
      tc = 4'd3; dir_down = 1'b1; periodic = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      e = 3; w = 0;
      for (int i = 0; i < 11; i++) begin
         chk("pd_cnt", 32'(cnt), 32'(e));
         chk("pd_wrap", 32'(wrap), 32'(w));
         chk("pd_done", 32'(done), 0);
         chk("pd_busy", 32'(busy), 1);
         w = (e == 0) ? 1 : 0;
         e = (e == 0) ? 3 : e - 1;
         step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("pd_stop_cnt", 32'(cnt), 0);
      chk("pd_stop_busy", 32'(busy), 0);
      // pause and stop, one-shot up tc=15
      tc = 4'd15; dir_down = 1'b0; periodic = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("ps_cnt6", 32'(cnt), 6);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ps_hold", 32'(cnt), 6);
         chk("ps_busy", 32'(busy), 1);
      end
      pause = 1'b0;
      step();
      chk("ps_resume_edge", 32'(cnt), 6);
      for (int i = 7; i <= 10; i++) begin
         step();
         chk("ps_resume", 32'(cnt), 32'(i));
      end
      stop = 1'b1; pause = 1'b1;
      step();
      stop = 1'b0; pause = 1'b0;
      chk("ps_stop_cnt", 32'(cnt), 0);
      chk("ps_stop_busy", 32'(busy), 0);
      chk("ps_stop_done", 32'(done), 0);
      step();
      chk("ps_after_done", 32'(done), 0);
      chk("ps_after_cnt", 32'(cnt), 0);
      // tc=0 one-shot with start held through DONE
      tc = 4'd0; start = 1'b1;
      step();
      chk("z_run_cnt", 32'(cnt), 0);
      chk("z_run_busy", 32'(busy), 1);
      chk("z_run_done", 32'(done), 0);
      step();
      chk("z_done", 32'(done), 1);
      chk("z_done_busy", 32'(busy), 0);
      step();
      start = 1'b0;
      chk("z_restart_busy", 32'(busy), 1);
      chk("z_restart_done", 32'(done), 0);
      chk("z_restart_cnt", 32'(cnt), 0);
      step();
      chk("z_done2", 32'(done), 1);
      step();
      chk("z_idle_busy", 32'(busy), 0);
      // live input changes ignored during a run
      tc = 4'd7; dir_down = 1'b0; periodic = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("ig_cnt0", 32'(cnt), 0);
      step();
      chk("ig_cnt1", 32'(cnt), 1);
      tc = 4'd2; dir_down = 1'b1; periodic = 1'b1;
      for (int i = 2; i <= 7; i++) begin
         start = i[0];
         step();
         chk("ig_cnt", 32'(cnt), 32'(i));
         chk("ig_done_low", 32'(done), 0);
      end
      start = 1'b0;
      step();
      chk("ig_done", 32'(done), 1);
      chk("ig_done_cnt", 32'(cnt), 7);
      step();
      chk("ig_once", 32'(done), 0);
      chk("ig_idle_busy", 32'(busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
